// File: rtl/posit8_decode_arbiter_if.sv
// rtl/posit8_decode_arbiter_if.sv - requester/result bundle for the shared posit(8,1) decoder
// master: requesters and result consumer; slave: the arbiter.
interface posit8_decode_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       out_valid;
  logic       out_ready;
  logic       out_tag;
  logic       out_sign;
  logic [3:0] out_regime;
  logic       out_expo;
  logic [3:0] out_frac;
  logic       out_zero;
  logic       out_nar;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_tag, out_sign,
           out_regime, out_expo, out_frac, out_zero, out_nar
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_tag, out_sign,
           out_regime, out_expo, out_frac, out_zero, out_nar
  );
endinterface

// File: rtl/posit8_decode_arbiter.sv
// rtl/posit8_decode_arbiter.sv - round-robin shared posit(8,1) field decoder with one output slot
// The winning word is decoded combinationally and registered with its requester tag.
module posit8_decode_arbiter #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  posit8_decode_arbiter_if.slave bus,
  output logic [CNT_W-1:0]       decode_count
);

  logic         slot_free;
  logic         grant;
  logic         ptr;
  logic         accept;
  logic [N-1:0] win_word;
  logic         d_sign;
  logic [6:0]   mag;
  logic [2:0]   run;
  logic         found;
  logic [6:0]   shifted;
  logic [4:0]   rest;
  logic [3:0]   d_regime;

  assign slot_free = ~bus.out_valid | bus.out_ready;

  // ptr=0 favours requester 0 when both are valid
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) grant = ptr;
    else                                  grant = bus.req1_valid;
  end

  assign bus.req0_ready = ~rst & slot_free & ~grant & bus.req0_valid;
  assign bus.req1_ready = ~rst & slot_free &  grant & bus.req1_valid;
  assign accept         = bus.req0_ready | bus.req1_ready;
  assign win_word       = grant ? bus.req1_data : bus.req0_data;

  always_comb begin
    d_sign = win_word[N-1];
    mag    = d_sign ? (~win_word[6:0] + 7'd1) : win_word[6:0];
    run    = 3'd7;
    found  = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (!found && (mag[i] != mag[6])) begin
        run   = 3'(6 - i);
        found = 1'b1;
      end
    end
    // drop the run plus its terminator; vacated low bits read as zero
    shifted  = mag << ({1'b0, run} + 4'd1);
    rest     = 5'(shifted >> 2);
    d_regime = mag[6] ? ({1'b0, run} - 4'd1) : (4'd0 - {1'b0, run});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr            <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_tag    <= 1'b0;
      bus.out_sign   <= 1'b0;
      bus.out_regime <= 4'd0;
      bus.out_expo   <= 1'b0;
      bus.out_frac   <= 4'd0;
      bus.out_zero   <= 1'b0;
      bus.out_nar    <= 1'b0;
      decode_count   <= '0;
    end else begin
      if (accept) begin
        bus.out_valid  <= 1'b1;
        bus.out_tag    <= grant;
        bus.out_sign   <= d_sign;
        bus.out_regime <= d_regime;
        bus.out_expo   <= rest[4];
        bus.out_frac   <= rest[3:0];
        bus.out_zero   <= (win_word == '0);
        bus.out_nar    <= (win_word == {1'b1, {(N-1){1'b0}}});
        ptr            <= ~grant;
        if (decode_count != {CNT_W{1'b1}}) decode_count <= decode_count + CNT_W'(1);
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_posit8_decode_arbiter.sv
// tb/tb_posit8_decode_arbiter.sv - self-checking bench for posit8_decode_arbiter
// Directed decode table, hand sequences for arbitration/stall/reset, then random traffic vs a model.
module tb_posit8_decode_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] decode_count;
  logic [3:0]  count_s;
  int          checks;
  int          failures;

  always #5 clk = ~clk;

  posit8_decode_arbiter_if bus ();
  posit8_decode_arbiter_if bus_s ();

  posit8_decode_arbiter #(.N(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .decode_count(decode_count)
  );

  // narrow-counter copy sees identical traffic to exercise saturation
  posit8_decode_arbiter #(.N(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s.slave), .decode_count(count_s)
  );

  assign bus_s.req0_valid = bus.req0_valid;
  assign bus_s.req0_data  = bus.req0_data;
  assign bus_s.req1_valid = bus.req1_valid;
  assign bus_s.req1_data  = bus.req1_data;
  assign bus_s.out_ready  = bus.out_ready;

  typedef struct {
    logic [7:0]  w;
    logic        port;
    logic [11:0] exp;   // {sign, regime, expo, frac, zero, nar}
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] dut_fields();
    return {bus.out_tag, bus.out_sign, bus.out_regime, bus.out_expo,
            bus.out_frac, bus.out_zero, bus.out_nar};
  endfunction

  // posit(8,1) field extraction from the bit-level rules using integer arithmetic
  function automatic logic [11:0] ref_decode(input logic [7:0] w);
    int   m, lead, r, k, nrest, rest;
    logic s;
    s     = w[7];
    m     = s ? ((128 - int'(w[6:0])) % 128) : int'(w[6:0]);
    lead  = (m >> 6) & 1;
    r     = 1;
    while (r < 7 && ((m >> (6 - r)) & 1) == lead) r++;
    k     = (lead == 1) ? r - 1 : -r;
    nrest = 7 - r - 1;
    if (nrest < 0) nrest = 0;
    rest  = m % (1 << nrest);
    rest  = rest << (5 - nrest);
    return {s, k[3:0], rest[4], rest[3:0], (w == 8'h00), (w == 8'h80)};
  endfunction

  task automatic send(input logic port, input logic [7:0] w, output logic got);
    got = 1'b0;
    @(negedge clk);
    if (port) begin bus.req1_valid = 1'b1; bus.req1_data = w; end
    else      begin bus.req0_valid = 1'b1; bus.req0_data = w; end
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((port ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic        got;
  logic [12:0] saved;
  // reference model state
  logic        m_valid;
  logic        m_last;
  logic [12:0] m_fields;
  int          m_count;

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{8'h40, 1'b0, {1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0}};
    vecs[1] = '{8'h50, 1'b1, {1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0}};
    vecs[2] = '{8'h00, 1'b1, {1'b0, 4'h9, 1'b0, 4'h0, 1'b1, 1'b0}};
    vecs[3] = '{8'h80, 1'b1, {1'b1, 4'h9, 1'b0, 4'h0, 1'b0, 1'b1}};
    vecs[4] = '{8'h7F, 1'b0, {1'b0, 4'h6, 1'b0, 4'h0, 1'b0, 1'b0}};
    vecs[5] = '{8'h01, 1'b1, {1'b0, 4'hA, 1'b0, 4'h0, 1'b0, 1'b0}};
    vecs[6] = '{8'h6B, 1'b0, {1'b0, 4'h1, 1'b1, 4'h6, 1'b0, 1'b0}};
    vecs[7] = '{8'hC0, 1'b1, {1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0}};
    vecs[8] = '{8'h35, 1'b0, {1'b0, 4'hF, 1'b1, 4'h5, 1'b0, 1'b0}};

    rst            = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h40;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h50;
    bus.out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid",  {63'd0, bus.out_valid}, 64'd0);
    check("reset_fields", {51'd0, dut_fields()}, 64'd0);
    check("reset_count",  {48'd0, decode_count}, 64'd0);
    check("reset_ready",  {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].port, vecs[i].w, got);
      check("send_grant",  {63'd0, got}, 64'd1);
      check("dec_valid",   {63'd0, bus.out_valid}, 64'd1);
      check("dec_fields",  {51'd0, dut_fields()}, {51'd0, vecs[i].port, vecs[i].exp});
      check("dec_count",   {48'd0, decode_count}, 64'(i + 1));
    end

    do_reset();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data  = 8'h40;
    bus.req1_data  = 8'h35;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("alt_ready", {62'd0, bus.req1_ready, bus.req0_ready},
            (i % 2 == 0) ? 64'd1 : 64'd2);
      @(negedge clk);
    end

    bus.out_ready = 1'b0;
    #1;
    saved = dut_fields();
    check("stall_tag",   {63'd0, bus.out_tag}, 64'd1);
    check("stall_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("stall_ready",  {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
      check("stall_hold",   {50'd0, bus.out_valid, dut_fields()}, {50'd0, 1'b1, saved});
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_grant", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd1);

    rst = 1'b1;
    #1;
    check("async_rst_valid",  {63'd0, bus.out_valid}, 64'd0);
    check("async_rst_fields", {51'd0, dut_fields()}, 64'd0);
    check("async_rst_count",  {44'd0, decode_count, count_s}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_grant", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd1);

    m_valid  = 1'b0;
    m_last   = 1'b1;
    m_fields = '0;
    m_count  = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic v0, v1, win, acc, slot;
      bus.req0_valid = ($urandom_range(0, 3) != 0);
      bus.req1_valid = ($urandom_range(0, 3) != 0);
      bus.req0_data  = 8'($urandom);
      bus.req1_data  = 8'($urandom);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      #1;
      v0   = bus.req0_valid;
      v1   = bus.req1_valid;
      slot = !m_valid || bus.out_ready;
      win  = (v0 && v1) ? ~m_last : v1;
      acc  = slot && (v0 || v1);
      check("rand_out", {48'd0, bus.req1_ready, bus.req0_ready, bus.out_valid, dut_fields()},
            {48'd0, acc && win, acc && !win, m_valid, m_fields});
      check("rand_count", {44'd0, decode_count, count_s},
            {44'd0, 16'(m_count), 4'((m_count > 15) ? 15 : m_count)});
      if (acc) begin
        m_valid  = 1'b1;
        m_last   = win;
        m_fields = {win, ref_decode(win ? bus.req1_data : bus.req0_data)};
        m_count++;
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
      @(negedge clk);
    end
    #1;
    check("sat_count", {60'd0, count_s}, 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/posit8_decode_arbiter.md
Name: posit8_decode_arbiter

Overview:
- Shares one combinational posit(8,1) field decoder between two requesters.
- Arbitration is round-robin. The block registers the decoded fields into a single output slot and drives it with a valid/ready handshake.
- It sits between the operand-fetch ports and the posit arithmetic pipeline. Each result carries a requester tag so downstream logic can return it to its source.

Parameters:
- N, 8, posit width. Only 8 is supported; it matches the team's posit(8,1) decoder.
- CNT_W, 16, width of the saturating decode-count register.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req0_valid  in  1  requester 0 holds a posit.
- req0_data  in  8  requester 0 posit word.
- req0_ready  out  1  requester 0 word accepted this cycle (when valid).
- req1_valid  in  1  requester 1 holds a posit.
- req1_data  in  8  requester 1 posit word.
- req1_ready  out  1  requester 1 word accepted this cycle (when valid).
- out_valid  out  1  output slot holds a decoded result.
- out_ready  in  1  consumer takes the result.
- out_tag  out  1  requester index of the result.
- out_sign  out  1  sign bit.
- out_regime  out  4  regime field (two's-complement k).
- out_expo  out  1  exponent bit.
- out_frac  out  4  fraction bits.
- out_zero  out  1  input was 0x00.
- out_nar  out  1  input was 0x80 (NaR).
- decode_count  out  CNT_W  number of accepted words, saturating.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0 and all out_* fields=0.
  - decode_count=0.
  - Round-robin pointer = requester 0 has priority.
  - req*_ready are forced 0 while rst is high.
- Slot availability: slot_free = ~out_valid | out_ready.
- Grant (combinational):
  - Only one requester valid: it wins.
  - Both valid: the one the pointer favours wins.
  - reqX_ready = slot_free & grant==X & reqX_valid.
  - At most one ready is high per cycle.
- Accept = a ready high at the rising edge. On accept:
  - The winner's word passes through the decoder and all fields load into the output registers.
  - out_tag = winner; out_valid=1 next cycle.
  - Pointer moves to favour the other requester.
  - decode_count increments, holding at 2^CNT_W-1.
- No accept and out_ready=1 with out_valid=1: out_valid clears next cycle. Fields hold their last values.
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 word/cycle while out_ready stays high. Simultaneous drain and accept in the same cycle keeps out_valid=1 with new contents (no bubble).
- Stall: out_valid=1 and out_ready=0:
  - All out_* fields stay stable.
  - Both ready outputs are 0.
  - The pointer does not move.
- Decode rules for the word w:
  - sign = w[7].
  - m = w[6:0] if sign=0, else two's complement of w[6:0] (7 bits).
  - Regime run: count of identical leading bits of m starting at m[6], terminated by the opposite bit or by the end of m. Call it r, range 1..7.
  - regime = r-1 if m[6]=1; regime = -r (4-bit two's complement) if m[6]=0.
  - After dropping the run and its terminator, the next bit is expo and the following 4 bits are frac. Bits shifted past the end read as 0.
  - zero = (w==0x00). nar = (w==0x80). Both are exclusive with each other.
- A requester deasserting valid without ready is allowed; no state changes.
- Reset mid-stall drops the held result; no result is replayed after reset.

Test Plan:
- Reset, then req0 sends 0x40 with out_ready=1 → 1 cycle later: out_valid=1, tag=0, sign=0, regime=0, expo=0, frac=0; decode_count=1.
- req1 sends 0x50 → tag=1, regime=0, expo=1, frac=0. req1 sends 0x00 → zero=1. req1 sends 0x80 → nar=1, sign=1.
- Both requesters valid continuously with out_ready=1 → grants alternate 0,1,0,1 after reset; one result per cycle; no cycle has both readys high.
- out_ready=0 for 3 cycles while both requesters are valid → out_* fields stable, both readys 0, pointer unchanged. Release → next grant goes to the requester the pointer favoured before the stall.
- Assert rst mid-stream with out_valid=1 → out_valid, fields and decode_count go to 0 immediately (asynchronous). The first grant after release goes to req0.
- Run with CNT_W=4 and 20 accepts → decode_count saturates at 15.
